// File: rtl/dma_mem_tester_if.sv
// bsg_cache-style DMA channels between an initiator (master) and the memory wrapper (slave).
// Packet channel, write-data channel and read-data channel.
interface dma_mem_tester_if #(
  parameter int addr_width_p = 28,
  parameter int data_width_p = 64
);
  logic [addr_width_p:0]   dma_pkt;
  logic                    dma_pkt_v;
  logic                    dma_pkt_yumi;
  logic [data_width_p-1:0] dma_data_out;
  logic                    dma_data_out_v;
  logic                    dma_data_out_yumi;
  logic [data_width_p-1:0] dma_data_in;
  logic                    dma_data_in_v;
  logic                    dma_data_in_ready_and;

  modport master (
    output dma_pkt,
    output dma_pkt_v,
    input  dma_pkt_yumi,
    output dma_data_out,
    output dma_data_out_v,
    input  dma_data_out_yumi,
    input  dma_data_in,
    input  dma_data_in_v,
    output dma_data_in_ready_and
  );

  modport slave (
    input  dma_pkt,
    input  dma_pkt_v,
    output dma_pkt_yumi,
    input  dma_data_out,
    input  dma_data_out_v,
    output dma_data_out_yumi,
    output dma_data_in,
    output dma_data_in_v,
    input  dma_data_in_ready_and
  );
endinterface

// File: rtl/dma_mem_tester.sv
// DMA built-in self-test: writes num_blocks_p blocks with a seeded pattern through the
// bsg_cache DMA channels, reads them back, and reports error count and first failing address.
module dma_mem_tester #(
  parameter int addr_width_p  = 28,
  parameter int data_width_p  = 64,
  parameter int block_beats_p = 8,
  parameter int num_blocks_p  = 16,
  parameter int base_addr_p   = 'h100
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    start_i,
  input  logic                    calib_done_i,
  input  logic [31:0]             seed_i,
  dma_mem_tester_if.master        dma,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    pass_o,
  output logic [15:0]             error_count_o,
  output logic [addr_width_p-1:0] first_err_addr_o
);

  localparam int blk_w_lp       = (num_blocks_p  > 1) ? $clog2(num_blocks_p)  : 1;
  localparam int beat_w_lp      = (block_beats_p > 1) ? $clog2(block_beats_p) : 1;
  localparam int beat_bytes_lp  = data_width_p / 8;
  localparam int block_bytes_lp = block_beats_p * beat_bytes_lp;

  localparam logic [blk_w_lp-1:0]  last_blk_lp  = blk_w_lp'(num_blocks_p - 1);
  localparam logic [beat_w_lp-1:0] last_beat_lp = beat_w_lp'(block_beats_p - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_CALIB,
    WR_PKT,
    WR_DATA,
    RD_PKT,
    RD_DATA,
    DONE
  } state_t;

  state_t state_r, state_n;

  logic [blk_w_lp-1:0]     blk_r;
  logic [beat_w_lp-1:0]    beat_r;
  logic [31:0]             seed_r;
  logic [15:0]             err_r;
  logic [addr_width_p-1:0] first_r;

  logic                    start_accept;
  logic                    pkt_v;
  logic                    pkt_write;
  logic                    wdata_v;
  logic                    rdata_ready;
  logic                    wr_xfer;
  logic                    rd_xfer;
  logic                    beat_xfer;
  logic                    last_beat;
  logic                    last_blk;
  logic                    rd_mismatch;
  logic [data_width_p-1:0] pattern;
  logic [addr_width_p-1:0] blk_addr;
  logic [addr_width_p-1:0] beat_addr;

  // Blocks are laid out contiguously from base_addr_p; the sum wraps silently at addr_width_p.
  assign blk_addr  = addr_width_p'(base_addr_p)
                   + addr_width_p'(blk_r) * addr_width_p'(block_bytes_lp);
  assign beat_addr = blk_addr + addr_width_p'(beat_r) * addr_width_p'(beat_bytes_lp);

  assign pattern     = data_width_p'({16'(blk_r), 16'(beat_r), seed_r ^ 32'hDEADBEEF});
  assign last_beat   = (beat_r == last_beat_lp);
  assign last_blk    = (blk_r == last_blk_lp);

  assign wr_xfer     = wdata_v & dma.dma_data_out_yumi;
  assign rd_xfer     = rdata_ready & dma.dma_data_in_v;
  assign beat_xfer   = wr_xfer | rd_xfer;
  assign rd_mismatch = (dma.dma_data_in != pattern);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      blk_r   <= '0;
      beat_r  <= '0;
      seed_r  <= '0;
      err_r   <= '0;
      first_r <= '0;
    end else begin
      state_r <= state_n;

      if (start_accept) begin
        seed_r  <= seed_i;
        err_r   <= '0;
        first_r <= '0;
        blk_r   <= '0;
        beat_r  <= '0;
      end

      // The block counter wraps after the write pass so the read pass restarts at block 0.
      if (beat_xfer) begin
        if (last_beat) begin
          beat_r <= '0;
          blk_r  <= last_blk ? '0 : blk_r + blk_w_lp'(1);
        end else begin
          beat_r <= beat_r + beat_w_lp'(1);
        end
      end

      if (rd_xfer && rd_mismatch) begin
        if (err_r != 16'hFFFF) begin
          err_r <= err_r + 16'd1;
        end
        if (err_r == 16'd0) begin
          first_r <= beat_addr;
        end
      end
    end
  end

  always_comb begin
    state_n      = state_r;
    start_accept = 1'b0;
    pkt_v        = 1'b0;
    pkt_write    = 1'b0;
    wdata_v      = 1'b0;
    rdata_ready  = 1'b0;

    unique case (state_r)
      IDLE, DONE: begin
        if (start_i) begin
          state_n      = WAIT_CALIB;
          start_accept = 1'b1;
        end
      end

      WAIT_CALIB: begin
        if (calib_done_i) begin
          state_n = WR_PKT;
        end
      end

      WR_PKT: begin
        pkt_v     = 1'b1;
        pkt_write = 1'b1;
        if (dma.dma_pkt_yumi) begin
          state_n = WR_DATA;
        end
      end

      WR_DATA: begin
        wdata_v = 1'b1;
        if (dma.dma_data_out_yumi && last_beat) begin
          state_n = last_blk ? RD_PKT : WR_PKT;
        end
      end

      RD_PKT: begin
        pkt_v = 1'b1;
        if (dma.dma_pkt_yumi) begin
          state_n = RD_DATA;
        end
      end

      RD_DATA: begin
        rdata_ready = 1'b1;
        if (dma.dma_data_in_v && last_beat) begin
          state_n = last_blk ? DONE : RD_PKT;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Payloads are forced to zero while their valid is low so idle outputs read as 0.
  assign dma.dma_pkt               = pkt_v   ? {pkt_write, blk_addr} : '0;
  assign dma.dma_pkt_v             = pkt_v;
  assign dma.dma_data_out          = wdata_v ? pattern : '0;
  assign dma.dma_data_out_v        = wdata_v;
  assign dma.dma_data_in_ready_and = rdata_ready;

  assign busy_o           = (state_r != IDLE) && (state_r != DONE);
  assign done_o           = (state_r == DONE);
  assign pass_o           = (state_r == DONE) && (err_r == 16'd0);
  assign error_count_o    = err_r;
  assign first_err_addr_o = first_r;

endmodule

// File: tb/tb_dma_mem_tester.sv
// Bench for dma_mem_tester: a memory responder with an independent transaction model,
// a table of full runs, and hand-written sequences for calibration, restart and reset.
module tb_dma_mem_tester;

  localparam int addr_width_lp  = 28;
  localparam int num_blocks_lp  = 16;
  localparam int block_beats_lp = 8;
  localparam int base_addr_lp   = 'h100;
  localparam int total_beats_lp = num_blocks_lp * block_beats_lp;
  localparam int run_cycles_lp  = 1 + 2 * num_blocks_lp * (1 + block_beats_lp);
  localparam int bound_lp       = 20000;

  typedef enum logic [1:0] {MODE_IDEAL, MODE_STALL, MODE_FLIP, MODE_ZERO} resp_mode_t;

  typedef struct {
    resp_mode_t               mode;
    logic [31:0]              seed;
    logic                     check_lat;
    logic                     exp_pass;
    logic [15:0]              exp_errs;
    logic [addr_width_lp-1:0] exp_first;
  } vec_t;

  logic                     clk;
  logic                     reset;
  logic                     start;
  logic                     calib;
  logic [31:0]              seed;
  logic                     busy;
  logic                     done;
  logic                     pass;
  logic [15:0]              error_count;
  logic [addr_width_lp-1:0] first_err_addr;

  dma_mem_tester_if #(.addr_width_p(addr_width_lp), .data_width_p(64)) bus ();

  dma_mem_tester #(
    .addr_width_p (addr_width_lp),
    .data_width_p (64),
    .block_beats_p(block_beats_lp),
    .num_blocks_p (num_blocks_lp),
    .base_addr_p  (base_addr_lp)
  ) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .start_i         (start),
    .calib_done_i    (calib),
    .seed_i          (seed),
    .dma             (bus),
    .busy_o          (busy),
    .done_o          (done),
    .pass_o          (pass),
    .error_count_o   (error_count),
    .first_err_addr_o(first_err_addr)
  );

  int checks = 0;
  int errors = 0;

  resp_mode_t               mode;
  logic [31:0]              model_seed;
  int                       txn;
  logic                     out_active;
  logic                     out_write;
  int                       out_blk;
  int                       out_beat;
  logic                     held_pkt_v;
  logic [addr_width_lp:0]   held_pkt;
  logic                     held_data_v;
  logic [63:0]              held_data;
  int                       model_errs;
  logic [addr_width_lp-1:0] model_first;
  logic                     model_first_set;
  int                       wr_beats;
  int                       rd_beats;
  logic [63:0]              mem [logic [addr_width_lp-1:0]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] pattern(input int b, input int k, input logic [31:0] s);
    return {b[15:0], k[15:0], s ^ 32'hDEADBEEF};
  endfunction

  function automatic logic [addr_width_lp-1:0] beat_addr(input int b, input int k);
    return addr_width_lp'(base_addr_lp + 64 * b + 8 * k);
  endfunction

  function automatic logic coin();
    return $urandom_range(0, 9) < 3;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Memory responder: drives yumi/valid at the negedge and books each handshake
  // that the following posedge will complete.
  task automatic responder_step();
    logic [addr_width_lp-1:0] a;
    logic [63:0]              rdata;
    logic                     wr;
    if (reset) begin
      out_active            = 1'b0;
      held_pkt_v            = 1'b0;
      held_data_v           = 1'b0;
      bus.dma_pkt_yumi      = 1'b0;
      bus.dma_data_out_yumi = 1'b0;
      bus.dma_data_in_v     = 1'b0;
      bus.dma_data_in       = '0;
      return;
    end
    if (held_pkt_v) begin
      checkOutput("pkt_stable", {bus.dma_pkt_v, bus.dma_pkt}, {1'b1, held_pkt});
    end
    if (held_data_v) begin
      checkOutput("wdata_v_stable", bus.dma_data_out_v, 1'b1);
      checkOutput("wdata_stable", bus.dma_data_out, held_data);
    end
    held_pkt_v  = 1'b0;
    held_data_v = 1'b0;

    bus.dma_pkt_yumi      = (mode == MODE_STALL) ? coin() : 1'b1;
    bus.dma_data_out_yumi = (mode == MODE_STALL) ? coin() : 1'b1;
    if (out_active && !out_write) begin
      a     = beat_addr(out_blk, out_beat);
      rdata = '0;
      if (mem.exists(a)) rdata = mem[a];
      if (mode == MODE_FLIP && out_blk == 3 && out_beat == 5) rdata[0] = ~rdata[0];
      if (mode == MODE_ZERO) rdata = '0;
      bus.dma_data_in_v = (mode == MODE_STALL) ? coin() : 1'b1;
      bus.dma_data_in   = rdata;
    end else begin
      bus.dma_data_in_v = (mode == MODE_STALL) ? coin() : 1'b0;
      bus.dma_data_in   = {$urandom, $urandom};
    end

    if (bus.dma_pkt_v) begin
      if (bus.dma_pkt_yumi) begin
        checkOutput("single_outstanding", out_active, 1'b0);
        checkOutput("txn_in_range", txn < 2 * num_blocks_lp, 1'b1);
        wr = (txn < num_blocks_lp);
        checkOutput("pkt", bus.dma_pkt, {wr, beat_addr(txn % num_blocks_lp, 0)});
        out_active = 1'b1;
        out_write  = wr;
        out_blk    = txn % num_blocks_lp;
        out_beat   = 0;
        txn++;
      end else begin
        held_pkt_v = 1'b1;
        held_pkt   = bus.dma_pkt;
      end
    end

    if (bus.dma_data_out_v) begin
      checkOutput("wdata_v_expected", out_active && out_write, 1'b1);
      if (bus.dma_data_out_yumi && out_active && out_write) begin
        checkOutput("wdata", bus.dma_data_out, pattern(out_blk, out_beat, model_seed));
        mem[beat_addr(out_blk, out_beat)] = bus.dma_data_out;
        wr_beats++;
        out_beat++;
        if (out_beat == block_beats_lp) out_active = 1'b0;
      end else if (!bus.dma_data_out_yumi) begin
        held_data_v = 1'b1;
        held_data   = bus.dma_data_out;
      end
    end

    if (bus.dma_data_in_ready_and) begin
      checkOutput("ready_expected", out_active && !out_write, 1'b1);
      if (bus.dma_data_in_v && out_active && !out_write) begin
        if (bus.dma_data_in !== pattern(out_blk, out_beat, model_seed)) begin
          model_errs++;
          if (!model_first_set) begin
            model_first     = beat_addr(out_blk, out_beat);
            model_first_set = 1'b1;
          end
        end
        rd_beats++;
        out_beat++;
        if (out_beat == block_beats_lp) out_active = 1'b0;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      responder_step();
    end
  end

  task automatic start_run(input logic [31:0] s);
    model_seed      = s;
    model_errs      = 0;
    model_first     = '0;
    model_first_set = 1'b0;
    txn             = 0;
    wr_beats        = 0;
    rd_beats        = 0;
    seed            = s;
    start           = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seed  = $urandom;
    checkOutput("start_clears_done", done, 1'b0);
    checkOutput("start_clears_pass", pass, 1'b0);
    checkOutput("start_clears_errs", error_count, 16'd0);
    checkOutput("start_clears_first", first_err_addr, '0);
    checkOutput("busy_after_start", busy, 1'b1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < bound_lp) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_within_bound", done, 1'b1);
  endtask

  task automatic applyStimulus(input vec_t v, output int lat);
    mode  = v.mode;
    calib = 1'b1;
    start_run(v.seed);
    wait_done(lat);
  endtask

  task automatic check_run_result(input vec_t v);
    checkOutput("done", done, 1'b1);
    checkOutput("busy_when_done", busy, 1'b0);
    checkOutput("pass", pass, v.exp_pass);
    checkOutput("error_count", error_count, v.exp_errs);
    checkOutput("first_err_addr", first_err_addr, v.exp_first);
    checkOutput("errs_vs_model", error_count, 16'(model_errs));
    checkOutput("first_vs_model", first_err_addr, model_first);
    checkOutput("wr_beats", wr_beats, total_beats_lp);
    checkOutput("rd_beats", rd_beats, total_beats_lp);
  endtask

  task automatic check_all_zero();
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_pass", pass, 1'b0);
    checkOutput("rst_errs", error_count, 16'd0);
    checkOutput("rst_first", first_err_addr, '0);
    checkOutput("rst_pkt_v", bus.dma_pkt_v, 1'b0);
    checkOutput("rst_pkt", bus.dma_pkt, '0);
    checkOutput("rst_wdata_v", bus.dma_data_out_v, 1'b0);
    checkOutput("rst_wdata", bus.dma_data_out, '0);
    checkOutput("rst_ready", bus.dma_data_in_ready_and, 1'b0);
  endtask

  initial begin
    vec_t vecs [5];
    vec_t final_vec;
    int   lat;
    int   n;
    int   bad;

    reset                 = 1'b1;
    start                 = 1'b0;
    calib                 = 1'b1;
    seed                  = '0;
    mode                  = MODE_IDEAL;
    txn                   = 0;
    out_active            = 1'b0;
    held_pkt_v            = 1'b0;
    held_data_v           = 1'b0;
    bus.dma_pkt_yumi      = 1'b0;
    bus.dma_data_out_yumi = 1'b0;
    bus.dma_data_in_v     = 1'b0;
    bus.dma_data_in       = '0;

    vecs[0] = '{MODE_IDEAL, 32'h0,      1'b1, 1'b1, 16'd0,   28'h0};
    vecs[1] = '{MODE_STALL, $urandom,   1'b0, 1'b1, 16'd0,   28'h0};
    vecs[2] = '{MODE_FLIP,  32'h1234,   1'b0, 1'b0, 16'd1,   28'h1E8};
    vecs[3] = '{MODE_ZERO,  32'h0,      1'b0, 1'b0, 16'd128, 28'h100};
    vecs[4] = '{MODE_IDEAL, $urandom,   1'b1, 1'b1, 16'd0,   28'h0};

    repeat (3) @(negedge clk);
    check_all_zero();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle_busy", busy, 1'b0);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i], lat);
      if (vecs[i].check_lat) checkOutput("run_latency", lat, run_cycles_lp);
      check_run_result(vecs[i]);
    end

    // Calibration gate: nothing may reach the bus until calib_done_i rises.
    mode  = MODE_IDEAL;
    calib = 1'b0;
    start_run(32'hCAFE0001);
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      if (bus.dma_pkt_v || !busy) bad++;
      @(negedge clk);
    end
    checkOutput("calib_wait_bad_cycles", bad, 0);
    calib = 1'b1;
    @(negedge clk);
    checkOutput("pkt_v_after_calib", bus.dma_pkt_v, 1'b1);
    wait_done(lat);
    check_run_result(vecs[0]);

    // Starts during a run must not restart it or reload the seed.
    start_run(32'h5EED_0002);
    repeat (40) @(negedge clk);
    checkOutput("busy_mid_write", busy, 1'b1);
    seed  = 32'hFFFF_0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (160) @(negedge clk);
    seed  = 32'h0F0F_0F0F;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    check_run_result(vecs[0]);

    // Reset in the read pass once errors have accumulated.
    mode = MODE_ZERO;
    start_run(32'h0);
    n = 0;
    while (error_count < 16'd3 && n < bound_lp) begin
      @(negedge clk);
      n++;
    end
    checkOutput("errs_before_reset", error_count >= 16'd3, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero();
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("idle_after_reset_busy", busy, 1'b0);
    checkOutput("idle_after_reset_pkt_v", bus.dma_pkt_v, 1'b0);

    // Reset in the middle of a write block, then a clean run from IDLE.
    mode = MODE_IDEAL;
    start_run(32'hABCD_1234);
    n = 0;
    while (wr_beats < 20 && n < bound_lp) begin
      @(negedge clk);
      n++;
    end
    checkOutput("mid_wr_data_v", bus.dma_data_out_v, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    final_vec = '{MODE_IDEAL, $urandom, 1'b1, 1'b1, 16'd0, 28'h0};
    applyStimulus(final_vec, lat);
    checkOutput("run_latency_after_reset", lat, run_cycles_lp);
    check_run_result(final_vec);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
